// File: rtl/axi4_lite_reg_master_if.sv
// Request/response and AXI4-Lite channel bundle for the register-access master.
// The master modport is the master's view; slave is the view of whatever sits around it.
interface axi4_lite_reg_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_wstrb;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      rsp_write;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic [1:0]                rsp_resp;
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
               awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
               awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
               awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
               awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready
    );
endinterface

// File: rtl/axi4_lite_reg_master.sv
// Single-outstanding AXI4-Lite master turning simple register requests into
// AW/W/B or AR/R transactions and returning one response per access.
module axi4_lite_reg_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    axi4_lite_reg_master_if.master bus,
    output logic [15:0]           err_count
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [STRB_WIDTH-1:0]   wstrb_r;
    logic                    write_r;
    logic                    awvalid_r;
    logic                    wvalid_r;
    logic                    arvalid_r;
    logic                    bready_r;
    logic                    rready_r;
    logic                    rsp_valid_r;
    logic                    rsp_write_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic [1:0]              rsp_resp_r;
    logic [15:0]             err_count_r;
    logic                    aw_fin_s;
    logic                    w_fin_s;

    // Error counter sticks at all-ones rather than wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    // A write channel is finished once its valid has dropped or it handshakes this cycle.
    always_comb begin
        aw_fin_s = 1'b0;
        w_fin_s  = 1'b0;
        if (state_r == WR_ADDR) begin
            aw_fin_s = !awvalid_r || bus.awready;
            w_fin_s  = !wvalid_r  || bus.wready;
        end else begin
            aw_fin_s = 1'b0;
            w_fin_s  = 1'b0;
        end
    end

    // Access sequencer with all channel handshakes and response payload registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            wstrb_r     <= {STRB_WIDTH{1'b0}};
            write_r     <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            bready_r    <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_resp_r  <= 2'b00;
            err_count_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_r  <= bus.req_addr;
                        wdata_r <= bus.req_wdata;
                        wstrb_r <= bus.req_wstrb;
                        write_r <= bus.req_write;
                        if (bus.req_write) begin
                            state_r   <= WR_ADDR;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                        end else begin
                            state_r   <= RD_ADDR;
                            arvalid_r <= 1'b1;
                        end
                    end
                end
                WR_ADDR: begin
                    // AW and W retire independently; neither is raised again this access.
                    if (bus.awready) begin
                        awvalid_r <= 1'b0;
                    end
                    if (bus.wready) begin
                        wvalid_r <= 1'b0;
                    end
                    if (aw_fin_s && w_fin_s) begin
                        state_r  <= WR_RESP;
                        bready_r <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bus.bvalid) begin
                        bready_r    <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_write_r <= 1'b1;
                        rsp_rdata_r <= {DATA_WIDTH{1'b0}};
                        rsp_resp_r  <= bus.bresp;
                        state_r     <= RSP;
                        if (bus.bresp != 2'b00) begin
                            err_count_r <= sat_inc16(err_count_r);
                        end
                    end
                end
                RD_ADDR: begin
                    if (bus.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.rvalid) begin
                        rready_r    <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_write_r <= 1'b0;
                        rsp_rdata_r <= bus.rdata;
                        rsp_resp_r  <= bus.rresp;
                        state_r     <= RSP;
                        if (bus.rresp != 2'b00) begin
                            err_count_r <= sat_inc16(err_count_r);
                        end
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    bready_r    <= 1'b0;
                    rready_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_r == IDLE);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_write = rsp_write_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_resp  = rsp_resp_r;
    assign bus.awvalid   = awvalid_r;
    assign bus.awaddr    = addr_r;
    assign bus.awprot    = 3'b000;
    assign bus.wvalid    = wvalid_r;
    assign bus.wdata     = wdata_r;
    assign bus.wstrb     = wstrb_r;
    assign bus.bready    = bready_r;
    assign bus.arvalid   = arvalid_r;
    assign bus.araddr    = addr_r;
    assign bus.arprot    = 3'b000;
    assign bus.rready    = rready_r;
    assign err_count     = err_count_r;

    // write_r is kept for debug visibility of the access in flight.
    logic unused_write_s;
    assign unused_write_s = write_r;

endmodule

// File: tb/tb_axi4_lite_reg_master.sv
// Self-checking bench: a cycle-driven slave model plus a response scoreboard.
`timescale 1ns/1ps
module tb_axi4_lite_reg_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] err_count;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_err = 16'd0;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          aw_cyc;
        int          w_cyc;
        int          ar_cyc;
        int          rdy_cyc;
        int          rsp_cyc;
        int          viol;
        logic        ready_after;
        logic        timeout;
    } obs_t;

    rsp_t sb_q[$];

    axi4_lite_reg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_reg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0; bus.req_wstrb = 4'd0; bus.rsp_ready = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'd0; bus.rresp = 2'b00;
    endtask

    function automatic logic [15:0] next_err(input logic [15:0] cur, input logic [1:0] resp);
        if (resp != 2'b00 && cur != 16'hFFFF) return cur + 16'd1;
        return cur;
    endfunction

    // Called at a negedge with the DUT idle; runs one access against a slave
    // that accepts AW/W/AR at the given cycles and answers B/R with zero wait.
    task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int aw_at, input int w_at, input int ar_at,
                              input logic [1:0] resp, input logic [31:0] rdata, input int rsp_dly,
                              output obs_t o);
        logic aw_done, w_done, ar_done, done;
        int   k, wait_n;
        o = '{write:1'b0, rdata:32'd0, resp:2'd0, aw_cyc:-1, w_cyc:-1, ar_cyc:-1, rdy_cyc:-1,
              rsp_cyc:-1, viol:0, ready_after:1'b0, timeout:1'b0};
        aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0; done = 1'b0; wait_n = 0;
        if (!bus.req_ready) o.viol++;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_wstrb = strb;
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 1;
        while (!done && !o.timeout) begin
            if (bus.awprot !== 3'b000 || bus.arprot !== 3'b000) o.viol++;
            if (bus.awvalid && (aw_done || bus.awaddr !== addr)) o.viol++;
            if (bus.wvalid && (w_done || bus.wdata !== wdata || bus.wstrb !== strb)) o.viol++;
            if (bus.arvalid && (ar_done || bus.araddr !== addr)) o.viol++;
            bus.awready = (k >= aw_at);
            bus.wready  = (k >= w_at);
            bus.arready = (k >= ar_at);
            if (bus.awvalid && bus.awready) begin aw_done = 1'b1; o.aw_cyc = k; end
            if (bus.wvalid && bus.wready) begin w_done = 1'b1; o.w_cyc = k; end
            if (bus.arvalid && bus.arready) begin ar_done = 1'b1; o.ar_cyc = k; end
            if ((bus.bready || bus.rready) && o.rdy_cyc < 0) o.rdy_cyc = k;
            bus.bvalid = bus.bready; bus.bresp = resp;
            bus.rvalid = bus.rready; bus.rdata = rdata; bus.rresp = resp;
            bus.rsp_ready = 1'b0;
            if (bus.rsp_valid) begin
                if (o.rsp_cyc < 0) begin
                    o.rsp_cyc = k; o.write = bus.rsp_write; o.rdata = bus.rsp_rdata; o.resp = bus.rsp_resp;
                end else if (o.write !== bus.rsp_write || o.rdata !== bus.rsp_rdata || o.resp !== bus.rsp_resp) begin
                    o.viol++;
                end
                if (bus.req_ready) o.viol++;
                if (wait_n >= rsp_dly) begin bus.rsp_ready = 1'b1; done = 1'b1; end
                else wait_n++;
            end
            @(negedge clk);
            k++;
            if (k > 80) o.timeout = 1'b1;
        end
        idle_inputs();
        o.ready_after = bus.req_ready;
        if (bus.rsp_valid) o.viol++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_valids: got %b expected 000000",
                {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid});
        end
        checks++;
        if ({bus.rsp_rdata, bus.rsp_resp, bus.rsp_write, err_count, bus.awaddr, bus.wdata} !== 115'd0) begin
            errors++; $display("FAIL reset_payload: rdata=%h resp=%b write=%b err=%h awaddr=%h wdata=%h expected all zero",
                bus.rsp_rdata, bus.rsp_resp, bus.rsp_write, err_count, bus.awaddr, bus.wdata);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.awprot !== 3'b000 || bus.arprot !== 3'b000) begin
            errors++; $display("FAIL reset_idle: req_ready=%b awprot=%b arprot=%b expected 1/000/000",
                bus.req_ready, bus.awprot, bus.arprot);
        end
        // Stray B/R responses while idle must be ignored.
        bus.bvalid = 1'b1; bus.bresp = 2'b10; bus.rvalid = 1'b1; bus.rresp = 2'b11;
        repeat (3) @(negedge clk);
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || err_count !== 16'd0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL spurious_resp: req_ready=%b err=%h rsp_valid=%b expected 1/0000/0",
                bus.req_ready, err_count, bus.rsp_valid);
        end
    endtask

    task automatic test_write_basic();
        obs_t o; rsp_t e;
        sb_q.push_back('{write:1'b1, rdata:32'd0, resp:2'b00});
        run_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 1, 99, 2'b00, 32'h55AA55AA, 0, o);
        e = sb_q.pop_front();
        checks++;
        if ({o.write, o.rdata, o.resp} !== {e.write, e.rdata, e.resp}) begin
            errors++; $display("FAIL wr_basic_rsp: got w=%b d=%h r=%b expected w=%b d=%h r=%b",
                o.write, o.rdata, o.resp, e.write, e.rdata, e.resp);
        end
        checks++;
        if (o.aw_cyc != 1 || o.w_cyc != 1 || o.rdy_cyc != 2 || o.rsp_cyc != 3) begin
            errors++; $display("FAIL wr_basic_latency: aw=%0d w=%0d bready=%0d rsp=%0d expected 1/1/2/3",
                o.aw_cyc, o.w_cyc, o.rdy_cyc, o.rsp_cyc);
        end
        checks++;
        if (o.viol != 0 || o.timeout !== 1'b0 || o.ready_after !== 1'b1 || err_count !== exp_err) begin
            errors++; $display("FAIL wr_basic_proto: viol=%0d timeout=%b ready_after=%b err=%h expected 0/0/1/%h",
                o.viol, o.timeout, o.ready_after, err_count, exp_err);
        end
    endtask

    task automatic test_read_delayed_ar();
        obs_t o; rsp_t e;
        sb_q.push_back('{write:1'b0, rdata:32'h12345678, resp:2'b00});
        run_access(1'b0, 32'h20, 32'hFFFFFFFF, 4'h0, 99, 99, 4, 2'b00, 32'h12345678, 0, o);
        e = sb_q.pop_front();
        checks++;
        if ({o.write, o.rdata, o.resp} !== {e.write, e.rdata, e.resp}) begin
            errors++; $display("FAIL rd_delay_rsp: got w=%b d=%h r=%b expected w=%b d=%h r=%b",
                o.write, o.rdata, o.resp, e.write, e.rdata, e.resp);
        end
        checks++;
        if (o.ar_cyc != 4 || o.rdy_cyc != 5 || o.rsp_cyc != 6 || o.viol != 0 || o.timeout !== 1'b0) begin
            errors++; $display("FAIL rd_delay_timing: ar=%0d rready=%0d rsp=%0d viol=%0d timeout=%b expected 4/5/6/0/0",
                o.ar_cyc, o.rdy_cyc, o.rsp_cyc, o.viol, o.timeout);
        end
    endtask

    task automatic test_write_w_first();
        obs_t o; rsp_t e;
        sb_q.push_back('{write:1'b1, rdata:32'd0, resp:2'b00});
        run_access(1'b1, 32'h34, 32'hA5A5F00F, 4'h6, 4, 1, 99, 2'b00, 32'h0, 0, o);
        e = sb_q.pop_front();
        checks++;
        if ({o.write, o.rdata, o.resp} !== {e.write, e.rdata, e.resp}) begin
            errors++; $display("FAIL wr_wfirst_rsp: got w=%b d=%h r=%b expected w=%b d=%h r=%b",
                o.write, o.rdata, o.resp, e.write, e.rdata, e.resp);
        end
        checks++;
        if (o.w_cyc != 1 || o.aw_cyc != 4 || o.rdy_cyc != 5 || o.rsp_cyc != 6) begin
            errors++; $display("FAIL wr_wfirst_timing: w=%0d aw=%0d bready=%0d rsp=%0d expected 1/4/5/6",
                o.w_cyc, o.aw_cyc, o.rdy_cyc, o.rsp_cyc);
        end
        checks++;
        if (o.viol != 0 || o.timeout !== 1'b0) begin
            errors++; $display("FAIL wr_wfirst_proto: viol=%0d timeout=%b expected 0/0", o.viol, o.timeout);
        end
    endtask

    task automatic test_read_slverr_backpressure();
        obs_t o; rsp_t e;
        sb_q.push_back('{write:1'b0, rdata:32'hCAFEF00D, resp:2'b10});
        exp_err = next_err(exp_err, 2'b10);
        run_access(1'b0, 32'h44, 32'h0, 4'h0, 99, 99, 1, 2'b10, 32'hCAFEF00D, 5, o);
        e = sb_q.pop_front();
        checks++;
        if ({o.write, o.rdata, o.resp} !== {e.write, e.rdata, e.resp}) begin
            errors++; $display("FAIL rd_slverr_rsp: got w=%b d=%h r=%b expected w=%b d=%h r=%b",
                o.write, o.rdata, o.resp, e.write, e.rdata, e.resp);
        end
        checks++;
        if (o.rsp_cyc != 3 || o.viol != 0 || o.ready_after !== 1'b1 || o.timeout !== 1'b0) begin
            errors++; $display("FAIL rd_slverr_hold: rsp=%0d viol=%0d ready_after=%b timeout=%b expected 3/0/1/0",
                o.rsp_cyc, o.viol, o.ready_after, o.timeout);
        end
        checks++;
        if (err_count !== 16'd1 || err_count !== exp_err) begin
            errors++; $display("FAIL rd_slverr_errcnt: got %h expected 0001", err_count);
        end
    endtask

    task automatic test_err_saturation();
        obs_t o; rsp_t e;
        force dut.err_count_r = 16'hFFFE;
        @(negedge clk);
        release dut.err_count_r;
        @(negedge clk);
        exp_err = 16'hFFFE;
        checks++;
        if (err_count !== exp_err) begin
            errors++; $display("FAIL sat_preload: got %h expected %h", err_count, exp_err);
        end
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{write:1'b1, rdata:32'd0, resp:2'b11});
            exp_err = next_err(exp_err, 2'b11);
            run_access(1'b1, 32'h100 + 32'(4 * i), 32'(i), 4'hF, 1, 1, 99, 2'b11, 32'h0, 0, o);
            e = sb_q.pop_front();
            checks++;
            if ({o.write, o.rdata, o.resp} !== {e.write, e.rdata, e.resp} || o.timeout !== 1'b0) begin
                errors++; $display("FAIL sat_rsp[%0d]: got w=%b d=%h r=%b t=%b expected w=%b d=%h r=%b",
                    i, o.write, o.rdata, o.resp, o.timeout, e.write, e.rdata, e.resp);
            end
            checks++;
            if (err_count !== 16'hFFFF || err_count !== exp_err) begin
                errors++; $display("FAIL sat_errcnt[%0d]: got %h expected ffff", i, err_count);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o; rsp_t e;
        int   seen;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h40;
        bus.req_wdata = 32'h0F0F0F0F; bus.req_wstrb = 4'hF;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
        for (int k = 0; k < 20 && !bus.bready; k++) @(negedge clk);
        checks++;
        if (bus.bready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_reach_wr_resp: bready=%b expected 1", bus.bready);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid} !== 6'b0 || err_count !== 16'd0) begin
            errors++; $display("FAIL rst_mid_async: valids=%b err=%h expected 000000/0000",
                {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid}, err_count);
        end
        idle_inputs();
        exp_err = 16'd0;
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        checks++;
        if (seen != 0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_release: rsp_valid_cycles=%0d req_ready=%b expected 0/1", seen, bus.req_ready);
        end
        sb_q.push_back('{write:1'b0, rdata:32'h0BADF00D, resp:2'b00});
        run_access(1'b0, 32'h80, 32'h0, 4'h0, 99, 99, 1, 2'b00, 32'h0BADF00D, 0, o);
        e = sb_q.pop_front();
        checks++;
        if ({o.write, o.rdata, o.resp} !== {e.write, e.rdata, e.resp} || o.rsp_cyc != 3 || o.viol != 0) begin
            errors++; $display("FAIL rst_mid_next_read: got w=%b d=%h r=%b rsp=%0d viol=%0d expected w=%b d=%h r=%b rsp=3 viol=0",
                o.write, o.rdata, o.resp, o.rsp_cyc, o.viol, e.write, e.rdata, e.resp);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o; rsp_t e;
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] data;
        int          aw_at, w_at, ar_at, exp_cyc;
        for (int i = 0; i < 8; i++) begin
            wr    = 1'($urandom_range(1, 0));
            resp  = 2'($urandom_range(3, 0));
            data  = $urandom;
            aw_at = $urandom_range(3, 1);
            w_at  = $urandom_range(3, 1);
            ar_at = $urandom_range(3, 1);
            exp_cyc = wr ? ((aw_at > w_at) ? aw_at : w_at) + 2 : ar_at + 2;
            sb_q.push_back('{write:wr, rdata:(wr ? 32'd0 : data), resp:resp});
            exp_err = next_err(exp_err, resp);
            run_access(wr, 32'h200 + 32'(4 * i), ~data, 4'($urandom_range(15, 0)),
                       wr ? aw_at : 99, wr ? w_at : 99, wr ? 99 : ar_at, resp, data,
                       $urandom_range(2, 0), o);
            e = sb_q.pop_front();
            checks++;
            if ({o.write, o.rdata, o.resp} !== {e.write, e.rdata, e.resp} || o.rsp_cyc != exp_cyc
                || o.viol != 0 || o.timeout !== 1'b0) begin
                errors++; $display("FAIL b2b[%0d]: got w=%b d=%h r=%b rsp=%0d viol=%0d t=%b expected w=%b d=%h r=%b rsp=%0d",
                    i, o.write, o.rdata, o.resp, o.rsp_cyc, o.viol, o.timeout, e.write, e.rdata, e.resp, exp_cyc);
            end
        end
        checks++;
        if (err_count !== exp_err) begin
            errors++; $display("FAIL b2b_errcnt: got %h expected %h", err_count, exp_err);
        end
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        test_reset();
        test_write_basic();
        test_read_delayed_ar();
        test_write_w_first();
        test_read_slverr_backpressure();
        test_err_saturation();
        test_reset_mid_access();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
